// File: rtl/fibo_pkg.sv
// Shared constants, FSM state encoding and sizing helpers for the fibonacci job arbiter.
package fibo_pkg;

   localparam int FIBO_N_W     = 5;
   localparam int FIBO_DATA_W  = 16;
   localparam int FIBO_TIMEOUT = 64;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      CLEAR   = 3'd1,
      START   = 3'd2,
      WAIT    = 3'd3,
      RESPOND = 3'd4
   } fibo_state_t;

   // Counter must hold TIMEOUT-1; never narrower than one bit.
   function automatic int fibo_cnt_w(input int timeout);
      return (timeout > 2) ? $clog2(timeout) : 1;
   endfunction

   localparam int FIBO_CNT_W = fibo_cnt_w(FIBO_TIMEOUT);

endpackage

// File: rtl/fibo_job_arbiter_rr_picker.sv
// Combinational round-robin search: first set request strictly after the pointer, wrapping.
module rr_picker #(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = 2
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] win_onehot,
   output logic [IDX_W-1:0]   win_idx,
   output logic               win_any
);

   int   cand_s;
   logic hit_s;

   // Walk candidates ptr+1 .. ptr+NUM_REQ; the first hit locks out the rest.
   always_comb begin
      win_onehot = '0;
      win_idx    = '0;
      win_any    = 1'b0;
      cand_s     = 0;
      hit_s      = 1'b0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         cand_s             = (int'(ptr) + i) % NUM_REQ;
         hit_s              = !win_any && req[cand_s];
         win_onehot[cand_s] = win_onehot[cand_s] | hit_s;
         win_idx            = hit_s ? IDX_W'(cand_s) : win_idx;
         win_any            = win_any | hit_s;
      end
   end

endmodule

// File: rtl/fibo_job_arbiter.sv
// Round-robin arbiter sharing one fibonacci calculator; runs one job at a time
// (clear, begin, wait for done or timeout) and returns a one-cycle response strobe.
module fibo_job_arbiter
   import fibo_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int N_W     = FIBO_N_W,
   parameter int DATA_W  = FIBO_DATA_W,
   parameter int TIMEOUT = FIBO_TIMEOUT
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic [NUM_REQ-1:0]     req,
   input  logic [NUM_REQ*N_W-1:0] req_n,
   output logic [NUM_REQ-1:0]     grant,
   output logic [NUM_REQ-1:0]     resp_valid,
   output logic [DATA_W-1:0]      resp_data,
   output logic                   resp_err,
   output logic                   calc_reset,
   output logic [N_W-1:0]         calc_input_s,
   output logic                   calc_begin,
   input  logic                   calc_done,
   input  logic [DATA_W-1:0]      calc_fibo_out
);

   localparam int                IDX_W    = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;
   localparam int                CNT_W    = fibo_cnt_w(TIMEOUT);
   localparam logic [CNT_W-1:0]  TMO_LAST = CNT_W'(TIMEOUT - 1);
   localparam logic [IDX_W-1:0]  PTR_RST  = IDX_W'(NUM_REQ - 1);

   fibo_state_t          state_r, state_nx_s;
   logic [IDX_W-1:0]     ptr_r, ptr_nx_s;
   logic [NUM_REQ-1:0]   grant_r, grant_nx_s;
   logic [NUM_REQ-1:0]   resp_valid_r, resp_valid_nx_s;
   logic [DATA_W-1:0]    resp_data_r, resp_data_nx_s;
   logic                 resp_err_r, resp_err_nx_s;
   logic [N_W-1:0]       operand_r, operand_nx_s;
   logic                 begin_r, begin_nx_s;
   logic [CNT_W-1:0]     cnt_r, cnt_nx_s;

   logic [NUM_REQ-1:0]   win_onehot_s;
   logic [IDX_W-1:0]     win_idx_s;
   logic                 win_any_s;
   logic [N_W-1:0]       sel_op_s;

   rr_picker #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_picker (
      .req        (req),
      .ptr        (ptr_r),
      .win_onehot (win_onehot_s),
      .win_idx    (win_idx_s),
      .win_any    (win_any_s)
   );

   assign sel_op_s = req_n[win_idx_s*N_W +: N_W];

   // Next-state and next-output logic; outputs are registered one edge later.
   always_comb begin
      state_nx_s      = state_r;
      ptr_nx_s        = ptr_r;
      grant_nx_s      = grant_r;
      resp_valid_nx_s = '0;
      resp_data_nx_s  = '0;
      resp_err_nx_s   = 1'b0;
      operand_nx_s    = operand_r;
      begin_nx_s      = 1'b0;
      cnt_nx_s        = cnt_r;
      case (state_r)
         IDLE: begin
            if (win_any_s) begin
               grant_nx_s   = win_onehot_s;
               ptr_nx_s     = win_idx_s;
               operand_nx_s = sel_op_s;
               if (sel_op_s == '0) begin
                  // Operand 0 is rejected without touching the calculator.
                  state_nx_s      = RESPOND;
                  resp_valid_nx_s = win_onehot_s;
                  resp_err_nx_s   = 1'b1;
               end else begin
                  state_nx_s = CLEAR;
               end
            end else begin
               grant_nx_s = '0;
            end
         end
         CLEAR: begin
            state_nx_s = START;
            begin_nx_s = 1'b1;
         end
         START: begin
            state_nx_s = WAIT;
            cnt_nx_s   = '0;
         end
         WAIT: begin
            if (calc_done) begin
               state_nx_s      = RESPOND;
               resp_valid_nx_s = grant_r;
               resp_data_nx_s  = calc_fibo_out;
            end else if (cnt_r == TMO_LAST) begin
               state_nx_s      = RESPOND;
               resp_valid_nx_s = grant_r;
               resp_err_nx_s   = 1'b1;
            end else begin
               cnt_nx_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
         end
         RESPOND: begin
            state_nx_s = IDLE;
            grant_nx_s = '0;
         end
         default: begin
            state_nx_s = IDLE;
            grant_nx_s = '0;
         end
      endcase
   end

   // State and output registers with synchronous active-high reset.
   always_ff @(posedge clk) begin
      if (reset_n) begin
         state_r      <= IDLE;
         ptr_r        <= PTR_RST;
         grant_r      <= '0;
         resp_valid_r <= '0;
         resp_data_r  <= '0;
         resp_err_r   <= 1'b0;
         operand_r    <= '0;
         begin_r      <= 1'b0;
         cnt_r        <= '0;
      end else begin
         state_r      <= state_nx_s;
         ptr_r        <= ptr_nx_s;
         grant_r      <= grant_nx_s;
         resp_valid_r <= resp_valid_nx_s;
         resp_data_r  <= resp_data_nx_s;
         resp_err_r   <= resp_err_nx_s;
         operand_r    <= operand_nx_s;
         begin_r      <= begin_nx_s;
         cnt_r        <= cnt_nx_s;
      end
   end

   assign grant        = grant_r;
   assign resp_valid   = resp_valid_r;
   assign resp_data    = resp_data_r;
   assign resp_err     = resp_err_r;
   assign calc_input_s = operand_r;
   assign calc_begin   = begin_r;
   assign calc_reset   = reset_n | (state_r == CLEAR);

endmodule

// File: tb/tb_fibo_job_arbiter.sv
// Directed bench for fibo_job_arbiter: a behavioural calculator, a response scoreboard
// fed by the stimulus process, and a negedge monitor that pops and compares.
module tb_fibo_job_arbiter;

   localparam int NUM_REQ = 4;
   localparam int N_W     = 5;
   localparam int DATA_W  = 16;
   localparam int TIMEOUT = 64;
   localparam int CALC_LAT = 3;

   logic                   clk = 1'b0;
   logic                   reset_n;
   logic [NUM_REQ-1:0]     req;
   logic [NUM_REQ*N_W-1:0] req_n;
   logic [NUM_REQ-1:0]     grant;
   logic [NUM_REQ-1:0]     resp_valid;
   logic [DATA_W-1:0]      resp_data;
   logic                   resp_err;
   logic                   calc_reset;
   logic [N_W-1:0]         calc_input_s;
   logic                   calc_begin;
   logic                   calc_done;
   logic [DATA_W-1:0]      calc_fibo_out;

   typedef struct {
      int idx;
      int data;
      int err;
   } exp_t;

   exp_t             exp_q[$];
   int               n_checks = 0;
   int               n_fail   = 0;
   logic [NUM_REQ-1:0] keep = '0;
   bit               stuck = 1'b0;

   fibo_job_arbiter #(
      .NUM_REQ (NUM_REQ),
      .N_W     (N_W),
      .DATA_W  (DATA_W),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .req           (req),
      .req_n         (req_n),
      .grant         (grant),
      .resp_valid    (resp_valid),
      .resp_data     (resp_data),
      .resp_err      (resp_err),
      .calc_reset    (calc_reset),
      .calc_input_s  (calc_input_s),
      .calc_begin    (calc_begin),
      .calc_done     (calc_done),
      .calc_fibo_out (calc_fibo_out)
   );

   always #5 clk = ~clk;

   function automatic logic [DATA_W-1:0] fib(input int n);
      logic [DATA_W-1:0] a, b, t;
      a = '0;
      b = 16'd1;
      for (int k = 0; k < n; k++) begin
         t = a + b;
         a = b;
         b = t;
      end
      return a;
   endfunction

   // Behavioural calculator: done rises CALC_LAT+1 edges after begin and holds until reset.
   logic             busy;
   int               lat_cnt;
   logic [DATA_W-1:0] res;
   always @(posedge clk) begin
      if (calc_reset) begin
         busy          <= 1'b0;
         calc_done     <= 1'b0;
         calc_fibo_out <= '0;
         lat_cnt       <= 0;
      end else if (calc_begin) begin
         busy    <= 1'b1;
         lat_cnt <= CALC_LAT;
         res     <= fib(int'(calc_input_s));
      end else if (busy && !stuck) begin
         if (lat_cnt == 0) begin
            busy          <= 1'b0;
            calc_done     <= 1'b1;
            calc_fibo_out <= res;
         end else begin
            lat_cnt <= lat_cnt - 1;
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic push(input int idx, input int data, input int err);
      exp_t e;
      e.idx  = idx;
      e.data = data;
      e.err  = err;
      exp_q.push_back(e);
   endtask

   task automatic set_op(input int i, input int v);
      req_n[i*N_W +: N_W] = N_W'(v);
   endtask

   task automatic wait_drain(input int bound);
      int k;
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!(exp_q.size() == 0 && grant == '0) && k < bound);
      if (k >= bound) check("drain_timeout", 32'd1, 32'd0);
   endtask

   task automatic wait_begin(input int bound);
      int k;
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!calc_begin && k < bound);
      if (k >= bound) check("begin_timeout", 32'd1, 32'd0);
   endtask

   // Monitor: pops the scoreboard on each strobe and releases the requester's req.
   always @(negedge clk) begin
      exp_t e;
      if (resp_valid != '0) begin
         if (exp_q.size() == 0) begin
            check("unexpected_resp", 32'(resp_valid), 32'd0);
         end else begin
            e = exp_q.pop_front();
            check("resp_valid", 32'(resp_valid), 32'd1 << e.idx);
            check("resp_data", 32'(resp_data), 32'(e.data));
            check("resp_err", 32'(resp_err), 32'(e.err));
            check("resp_grant", 32'(grant), 32'(resp_valid));
         end
         for (int i = 0; i < NUM_REQ; i++) begin
            if (resp_valid[i]) begin
               if (keep[i]) keep[i] = 1'b0;
               else req[i] = 1'b0;
            end
         end
      end else if (!reset_n) begin
         check("idle_data", 32'(resp_data), 32'd0);
      end
   end

   initial begin
      int n;
      int pulses;
      req     = '0;
      req_n   = '0;
      reset_n = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_grant", 32'(grant), 32'd0);
      check("rst_resp_valid", 32'(resp_valid), 32'd0);
      check("rst_calc_reset", 32'(calc_reset), 32'd1);
      check("rst_calc_begin", 32'(calc_begin), 32'd0);
      check("rst_calc_input", 32'(calc_input_s), 32'd0);
      reset_n = 1'b0;
      @(negedge clk);
      check("rel_calc_reset", 32'(calc_reset), 32'd0);

      // All four at once: order 0,1,2,3; fib(3..6)=2,3,5,8.
      set_op(0, 3); set_op(1, 4); set_op(2, 5); set_op(3, 6);
      push(0, 2, 0); push(1, 3, 0); push(2, 5, 0); push(3, 8, 0);
      req = 4'b1111;
      wait_drain(400);

      // Single requester, operand 10 -> 55, with latency checks.
      set_op(0, 10);
      push(0, 55, 0);
      req[0] = 1'b1;
      @(negedge clk);
      check("t1_grant", 32'(grant), 32'd1);
      check("t1_clear", 32'(calc_reset), 32'd1);
      check("t1_nobegin", 32'(calc_begin), 32'd0);
      check("t1_input", 32'(calc_input_s), 32'd10);
      @(negedge clk);
      check("t1_clear_end", 32'(calc_reset), 32'd0);
      check("t1_begin", 32'(calc_begin), 32'd1);
      @(negedge clk);
      check("t1_begin_end", 32'(calc_begin), 32'd0);
      check("t1_grant_hold", 32'(grant), 32'd1);
      wait_drain(200);

      // Fairness: 1 keeps req high after its response; 2 must be served next.
      set_op(1, 7); set_op(2, 8);
      keep[1] = 1'b1;
      push(1, 13, 0); push(2, 21, 0); push(1, 13, 0);
      req[1] = 1'b1; req[2] = 1'b1;
      wait_drain(400);

      // Operand 0 on requester 3: immediate error, calculator untouched.
      set_op(3, 0);
      push(3, 0, 1);
      req[3] = 1'b1;
      pulses = 0;
      @(negedge clk);
      check("op0_resp_at_1", 32'(resp_valid), 32'h8);
      for (int k = 0; k < 3; k++) begin
         if (calc_reset || calc_begin) pulses++;
         @(negedge clk);
      end
      check("op0_no_calc", 32'(pulses), 32'd0);
      wait_drain(50);

      // Timeout with done stuck low: 64 WAIT cycles after START.
      stuck = 1'b1;
      set_op(0, 5);
      push(0, 0, 1);
      req[0] = 1'b1;
      wait_begin(20);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!resp_valid[0] && n < 200);
      check("tmo_wait_cycles", 32'(n - 1), 32'(TIMEOUT));
      wait_drain(20);
      stuck = 1'b0;
      set_op(1, 9);
      push(1, 34, 0);
      req[1] = 1'b1;
      @(negedge clk);
      check("post_tmo_clear", 32'(calc_reset), 32'd1);
      wait_drain(200);

      // Reset in the middle of WAIT: job abandoned, then re-granted and completed.
      set_op(2, 12);
      push(2, 144, 0);
      req[2] = 1'b1;
      wait_begin(20);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      check("mid_rst_grant", 32'(grant), 32'd0);
      check("mid_rst_resp", 32'(resp_valid), 32'd0);
      check("mid_rst_data", 32'(resp_data), 32'd0);
      check("mid_rst_begin", 32'(calc_begin), 32'd0);
      check("mid_rst_input", 32'(calc_input_s), 32'd0);
      check("mid_rst_calc_reset", 32'(calc_reset), 32'd1);
      reset_n = 1'b0;
      wait_drain(200);
      check("queue_empty", 32'(exp_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog expired");
   end

endmodule
